// File: rtl/lenet_frame_scheduler.sv
// Frame scheduler for the LeNet capture path: arms the pixel core for one frame,
// launches the accelerator once the buffer is full, latches the class and enforces gap/timeout.
module lenet_frame_scheduler #(
    parameter int unsigned GAP_FRAMES = 2,
    parameter int unsigned TIMEOUT    = 1_000_000,
    parameter int unsigned TO_W       = $clog2(TIMEOUT + 1)
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       trig,
    input  logic       auto_en,
    input  logic       frame_sync,
    input  logic       data_ready,
    input  logic       lenet_done,
    input  logic [3:0] lenet_class,
    output logic       lenet_signal,
    output logic       lenet_start,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       timeout_err,
    output logic       sync_err
);

    localparam int unsigned GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_START,
        S_RUN,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [3:0]      result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic            timeout_err_q, timeout_err_d;
    logic            sync_err_q, sync_err_d;
    logic            lenet_signal_q, lenet_start_q, busy_q;

    // State, counters and registered outputs; strobes decode from the next state.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            to_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            sync_err_q     <= 1'b0;
            lenet_signal_q <= 1'b0;
            lenet_start_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            sync_err_q     <= sync_err_d;
            lenet_signal_q <= (state_d == S_ARM) || (state_d == S_CAPTURE);
            lenet_start_q  <= (state_d == S_START);
            busy_q         <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timeout_err_d  = timeout_err_q;
        sync_err_d     = sync_err_q;
        case (state_q)
            S_IDLE: begin
                if (trig || auto_en) begin
                    state_d        = S_ARM;
                    result_valid_d = 1'b0;
                    timeout_err_d  = 1'b0;
                    sync_err_d     = 1'b0;
                end
            end
            S_ARM: begin
                if (frame_sync) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A wrap before the buffer completes means the frame was lost.
                if (data_ready) begin
                    state_d = S_START;
                end else if (frame_sync) begin
                    sync_err_d = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (lenet_done) begin
                    result_d       = lenet_class;
                    result_valid_d = 1'b1;
                    gap_cnt_d      = '0;
                    state_d        = S_GAP;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                if (GAP_FRAMES == 0) begin
                    state_d = S_IDLE;
                end else if (frame_sync) begin
                    if (gap_cnt_q == GW'(GAP_FRAMES - 1)) state_d = S_IDLE;
                    else gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lenet_signal = lenet_signal_q;
    assign lenet_start  = lenet_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_lenet_frame_scheduler.sv
// Directed bench for lenet_frame_scheduler: a GAP_FRAMES=2 instance for the main flows
// and a TIMEOUT=50 / GAP_FRAMES=0 instance for timeout behaviour.
module tb_lenet_frame_scheduler;

    logic       clk25, rst_n;
    logic       trig, auto_en, trig_t, auto_en_t;
    logic       frame_sync, data_ready, lenet_done;
    logic [3:0] lenet_class;
    logic       lenet_signal, lenet_start, result_valid, busy, timeout_err, sync_err;
    logic [3:0] result;
    logic       lenet_signal_t, lenet_start_t, result_valid_t, busy_t, timeout_err_t, sync_err_t;
    logic [3:0] result_t;

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    lenet_frame_scheduler #(.GAP_FRAMES(2), .TIMEOUT(1000)) dut (
        .clk25(clk25), .rst_n(rst_n), .trig(trig), .auto_en(auto_en),
        .frame_sync(frame_sync), .data_ready(data_ready), .lenet_done(lenet_done),
        .lenet_class(lenet_class), .lenet_signal(lenet_signal), .lenet_start(lenet_start),
        .result(result), .result_valid(result_valid), .busy(busy),
        .timeout_err(timeout_err), .sync_err(sync_err)
    );

    lenet_frame_scheduler #(.GAP_FRAMES(0), .TIMEOUT(50)) dut_t (
        .clk25(clk25), .rst_n(rst_n), .trig(trig_t), .auto_en(auto_en_t),
        .frame_sync(frame_sync), .data_ready(data_ready), .lenet_done(lenet_done),
        .lenet_class(lenet_class), .lenet_signal(lenet_signal_t), .lenet_start(lenet_start_t),
        .result(result_t), .result_valid(result_valid_t), .busy(busy_t),
        .timeout_err(timeout_err_t), .sync_err(sync_err_t)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    // Cycles in which the main instance drives lenet_start high.
    always @(posedge clk25) if (lenet_start === 1'b1) n_start++;

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_trig();
        trig = 1'b1; step(); trig = 1'b0;
    endtask

    task automatic pulse_trig_t();
        trig_t = 1'b1; step(); trig_t = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1; step(); frame_sync = 1'b0;
    endtask

    task automatic pulse_dr();
        data_ready = 1'b1; step(); data_ready = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] cls);
        lenet_done = 1'b1; lenet_class = cls; step(); lenet_done = 1'b0; lenet_class = 4'd0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst_n = 1'b0;
        idle(2);
        obs = {lenet_signal, lenet_start, result_valid, busy, timeout_err, sync_err, result};
        checks++; if (obs !== 10'd0) begin errors++; $display("FAIL reset_main: got %b expected 0", obs); end
        obs = {lenet_signal_t, lenet_start_t, result_valid_t, busy_t, timeout_err_t, sync_err_t, result_t};
        checks++; if (obs !== 10'd0) begin errors++; $display("FAIL reset_t: got %b expected 0", obs); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_shot();
        int s0;
        s0 = n_start;
        pulse_trig();
        checks++; if (lenet_signal !== 1'b1) begin errors++; $display("FAIL ss_signal_after_trig: got %b expected 1", lenet_signal); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy: got %b expected 1", busy); end
        idle(4);
        pulse_fs();
        checks++; if (lenet_signal !== 1'b1) begin errors++; $display("FAIL ss_signal_capture: got %b expected 1", lenet_signal); end
        idle(999);
        pulse_dr();
        checks++; if (lenet_start !== 1'b1) begin errors++; $display("FAIL ss_start: got %b expected 1", lenet_start); end
        checks++; if (lenet_signal !== 1'b0) begin errors++; $display("FAIL ss_signal_drop: got %b expected 0", lenet_signal); end
        step();
        checks++; if (lenet_start !== 1'b0) begin errors++; $display("FAIL ss_start_width: got %b expected 0", lenet_start); end
        idle(298);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ss_valid_early: got %b expected 0", result_valid); end
        pulse_done(4'd7);
        checks++; if (result !== 4'd7) begin errors++; $display("FAIL ss_result: got %0d expected 7", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL ss_valid: got %b expected 1", result_valid); end
        checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL ss_start_count: got %0d expected 1", n_start - s0); end
        pulse_fs();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy_gap: got %b expected 1", busy); end
        pulse_fs();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy_end: got %b expected 0", busy); end
        checks++; if ({result_valid, result} !== 5'h17) begin errors++; $display("FAIL ss_persist: got %h expected 17", {result_valid, result}); end
    endtask

    task automatic test_auto();
        logic [3:0] cls [3];
        int s0;
        cls[0] = 4'd3; cls[1] = 4'd5; cls[2] = 4'd9;
        s0 = n_start;
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (lenet_signal !== 1'b1) begin errors++; $display("FAIL auto_arm_%0d: got %b expected 1", i, lenet_signal); end
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL auto_valid_clr_%0d: got %b expected 0", i, result_valid); end
            pulse_fs();
            idle(10);
            pulse_dr();
            if (i == 2) auto_en = 1'b0;
            idle(20);
            pulse_done(cls[i]);
            checks++; if (result !== cls[i]) begin errors++; $display("FAIL auto_result_%0d: got %0d expected %0d", i, result, cls[i]); end
            for (int g = 0; g < 2; g++) begin
                idle(5);
                checks++; if (lenet_signal !== 1'b0) begin errors++; $display("FAIL auto_skip_%0d_%0d: got %b expected 0", i, g, lenet_signal); end
                pulse_fs();
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL auto_idle_%0d: got %b expected 0", i, busy); end
        end
        idle(3);
        checks++; if ({busy, lenet_signal} !== 2'b00) begin errors++; $display("FAIL auto_no_rearm: got %b expected 00", {busy, lenet_signal}); end
        checks++; if (n_start - s0 !== 3) begin errors++; $display("FAIL auto_runs: got %0d expected 3", n_start - s0); end
    endtask

    task automatic test_timeout();
        pulse_trig_t();
        pulse_fs();
        idle(3);
        pulse_dr();
        checks++; if (lenet_start_t !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", lenet_start_t); end
        idle(50);
        checks++; if (timeout_err_t !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout_err_t); end
        step();
        checks++; if (timeout_err_t !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", timeout_err_t); end
        checks++; if (result_valid_t !== 1'b0) begin errors++; $display("FAIL to_valid: got %b expected 0", result_valid_t); end
        step();
        checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL to_gap0_idle: got %b expected 0", busy_t); end
        pulse_trig_t();
        checks++; if (timeout_err_t !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_err_t); end
        pulse_fs();
        pulse_dr();
        idle(50);
        pulse_done(4'd4);
        checks++; if ({result_valid_t, result_t} !== 5'h14) begin errors++; $display("FAIL to_done_collide: got %h expected 14", {result_valid_t, result_t}); end
        checks++; if (timeout_err_t !== 1'b0) begin errors++; $display("FAIL to_no_err: got %b expected 0", timeout_err_t); end
        idle(2);
    endtask

    task automatic test_sync_err();
        int s0;
        s0 = n_start;
        pulse_trig();
        pulse_fs();
        idle(5);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL se_early: got %b expected 0", sync_err); end
        pulse_fs();
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL se_flag: got %b expected 1", sync_err); end
        checks++; if ({busy, lenet_signal} !== 2'b10) begin errors++; $display("FAIL se_gap: got %b expected 10", {busy, lenet_signal}); end
        pulse_dr();
        checks++; if (lenet_start !== 1'b0) begin errors++; $display("FAIL se_dr_ignored: got %b expected 0", lenet_start); end
        pulse_fs();
        pulse_fs();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL se_idle: got %b expected 0", busy); end
        pulse_dr();
        checks++; if ({busy, lenet_start} !== 2'b00) begin errors++; $display("FAIL se_idle_dr: got %b expected 00", {busy, lenet_start}); end
        checks++; if (n_start - s0 !== 0) begin errors++; $display("FAIL se_no_start: got %0d expected 0", n_start - s0); end
    endtask

    task automatic test_collisions();
        pulse_trig();
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL col_se_clear: got %b expected 0", sync_err); end
        pulse_fs();
        idle(5);
        frame_sync = 1'b1; data_ready = 1'b1;
        step();
        frame_sync = 1'b0; data_ready = 1'b0;
        checks++; if ({lenet_start, sync_err} !== 2'b10) begin errors++; $display("FAIL col_dr_fs: got %b expected 10", {lenet_start, sync_err}); end
        idle(5);
        pulse_trig();
        pulse_done(4'd2);
        checks++; if ({result_valid, result} !== 5'h12) begin errors++; $display("FAIL col_result: got %h expected 12", {result_valid, result}); end
        pulse_fs();
        pulse_fs();
        idle(3);
        checks++; if ({busy, lenet_signal} !== 2'b00) begin errors++; $display("FAIL col_trig_dropped: got %b expected 00", {busy, lenet_signal}); end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] obs;
        pulse_trig();
        pulse_fs();
        pulse_dr();
        idle(10);
        #5 rst_n = 1'b0;
        #1;
        obs = {lenet_signal, lenet_start, result_valid, busy, timeout_err, sync_err, result};
        checks++; if (obs !== 10'd0) begin errors++; $display("FAIL rst_run: got %b expected 0", obs); end
        step();
        rst_n = 1'b1;
        step();
        pulse_trig();
        checks++; if (lenet_signal !== 1'b1) begin errors++; $display("FAIL rst_rearm: got %b expected 1", lenet_signal); end
        pulse_fs();
        pulse_dr();
        checks++; if (lenet_start !== 1'b1) begin errors++; $display("FAIL rst_start: got %b expected 1", lenet_start); end
        idle(5);
        pulse_done(4'd6);
        checks++; if ({result_valid, result} !== 5'h16) begin errors++; $display("FAIL rst_result: got %h expected 16", {result_valid, result}); end
        pulse_fs();
        pulse_fs();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b expected 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b0; auto_en = 1'b0; trig_t = 1'b0; auto_en_t = 1'b0;
        frame_sync = 1'b0; data_ready = 1'b0; lenet_done = 1'b0; lenet_class = 4'd0;
        test_reset();
        test_single_shot();
        test_auto();
        test_timeout();
        test_sync_err();
        test_collisions();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
